bp_be_dcache_port_arbiter: RTL and testbench

Arbitrates the single D$ request port between the integer/FP memory pipeline and the page-table walker (PTW). It grants ownership, drains in-flight pipeline accesses before handing the port to the PTW, and tracks the owner of each request through the D$ TL and TV stages. Using those tags, it steers the per-stage physical tag to the D$ and the early-valid responses back to the correct requester. It sits between the memory pipe / PTW and bp_be_dcache, and replaces an ad-hoc busy-based mux.

---
 rtl/bp_be_dcache_port_arbiter.sv | 127 ++++++++++++
 tb/tb_bp_be_dcache_port_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_dcache_port_arbiter.sv
// rtl/bp_be_dcache_port_arbiter.sv - D$ request port arbiter between memory pipe and page-table walker
//
// Purpose: grants the single D$ request port to either the memory pipeline or the
// PTW. Pipe accesses still in flight are drained before the PTW is granted. The owner
// of each access is tagged through the TL and TV stages, so the physical tag goes to
// the D$ from the right requester and early-valid responses go back to it.
//
// Ports:
//   clk_i, reset_i                 clock, asynchronous active-high reset
//   flush_i                        kill live pipe-owned TL/TV entries
//   pipe_v_i/pipe_pkt_i/pipe_ready_o       pipe request handshake
//   pipe_ptag_i/pipe_ptag_v_i              pipe physical tag (cycle after accept)
//   pipe_early_v_o/pipe_miss_o             pipe TV-stage response
//   ptw_req_i/ptw_grant_o                  PTW port ownership request / grant
//   ptw_v_i/ptw_pkt_i/ptw_ready_o          PTW request handshake
//   ptw_ptag_i/ptw_ptag_v_i/ptw_early_v_o  PTW tag and response
//   dcache_v_o/dcache_pkt_o/dcache_ready_i request to the D$
//   dcache_ptag_o/dcache_ptag_v_o          TL-stage tag to the D$
//   dcache_early_v_i                       TV-stage early valid from the D$
module bp_be_dcache_port_arbiter #(
  parameter int pkt_width_p  = 82,
  parameter int ptag_width_p = 28
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    flush_i,

  input  logic                    pipe_v_i,
  input  logic [pkt_width_p-1:0]  pipe_pkt_i,
  output logic                    pipe_ready_o,
  input  logic [ptag_width_p-1:0] pipe_ptag_i,
  input  logic                    pipe_ptag_v_i,
  output logic                    pipe_early_v_o,
  output logic                    pipe_miss_o,

  input  logic                    ptw_req_i,
  output logic                    ptw_grant_o,
  input  logic                    ptw_v_i,
  input  logic [pkt_width_p-1:0]  ptw_pkt_i,
  output logic                    ptw_ready_o,
  input  logic [ptag_width_p-1:0] ptw_ptag_i,
  input  logic                    ptw_ptag_v_i,
  output logic                    ptw_early_v_o,

  output logic                    dcache_v_o,
  output logic [pkt_width_p-1:0]  dcache_pkt_o,
  input  logic                    dcache_ready_i,
  output logic [ptag_width_p-1:0] dcache_ptag_o,
  output logic                    dcache_ptag_v_o,
  input  logic                    dcache_early_v_i
);

  typedef enum logic [1:0] {
    S_PIPE  = 2'd0,
    S_DRAIN = 2'd1,
    S_PTW   = 2'd2
  } state_e;

  localparam logic OWNER_PIPE = 1'b0;
  localparam logic OWNER_PTW  = 1'b1;

  state_e state;
  logic   tl_live, tl_owner;
  logic   tv_live, tv_owner;

  logic pipe_accept, ptw_accept;
  logic tl_pipe_live, tv_pipe_live;
  logic pipe_pending;

  // Acceptance is gated by reset so no handshake is offered while reset is held,
  // even though the state register already sits in PIPE.
  assign pipe_ready_o = ~reset_i & (state == S_PIPE) & ~ptw_req_i & dcache_ready_i;
  assign ptw_ready_o  = ~reset_i & (state == S_PTW) & dcache_ready_i;
  assign ptw_grant_o  = ~reset_i & (state == S_PTW);

  assign pipe_accept = pipe_v_i & pipe_ready_o;
  assign ptw_accept  = ptw_v_i & ptw_ready_o;

  assign dcache_v_o   = pipe_accept | ptw_accept;
  assign dcache_pkt_o = (state == S_PTW) ? ptw_pkt_i : pipe_pkt_i;

  assign tl_pipe_live = tl_live & (tl_owner == OWNER_PIPE);
  assign tv_pipe_live = tv_live & (tv_owner == OWNER_PIPE);

  // A flushed pipe entry is gone at the next edge, so it no longer holds off the
  // handoff; this is what lets a flush shorten the drain.
  assign pipe_pending = (tl_pipe_live | tv_pipe_live) & ~flush_i;

  assign dcache_ptag_o   = (tl_owner == OWNER_PTW) ? ptw_ptag_i : pipe_ptag_i;
  assign dcache_ptag_v_o = tl_live
                         & ((tl_owner == OWNER_PTW) ? ptw_ptag_v_i : pipe_ptag_v_i)
                         & ~(flush_i & (tl_owner == OWNER_PIPE));

  assign pipe_early_v_o = dcache_early_v_i & tv_pipe_live & ~flush_i;
  assign pipe_miss_o    = tv_pipe_live & ~dcache_early_v_i & ~flush_i;
  assign ptw_early_v_o  = dcache_early_v_i & tv_live & (tv_owner == OWNER_PTW);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state    <= S_PIPE;
      tl_live  <= 1'b0;
      tl_owner <= OWNER_PIPE;
      tv_live  <= 1'b0;
      tv_owner <= OWNER_PIPE;
    end else begin
      case (state)
        // With nothing of the pipe in flight the drain is skipped entirely.
        S_PIPE:  if (ptw_req_i) state <= pipe_pending ? S_DRAIN : S_PTW;
        S_DRAIN: begin
          if (!ptw_req_i)        state <= S_PIPE;
          else if (!pipe_pending) state <= S_PTW;
        end
        S_PTW:   if (!ptw_req_i) state <= S_PIPE;
        default: state <= S_PIPE;
      endcase

      // A new accept always enters TL live, even during a flush: the flush only
      // targets accesses already in flight.
      tl_live <= pipe_accept | ptw_accept;
      if (pipe_accept | ptw_accept) tl_owner <= ptw_accept ? OWNER_PTW : OWNER_PIPE;

      tv_live  <= tl_live & ~(flush_i & (tl_owner == OWNER_PIPE));
      tv_owner <= tl_owner;
    end
  end

endmodule

// File: tb/tb_bp_be_dcache_port_arbiter.sv
// tb/tb_bp_be_dcache_port_arbiter.sv - self-checking bench for bp_be_dcache_port_arbiter
module tb_bp_be_dcache_port_arbiter;

  localparam int PW = 82;
  localparam int TW = 28;

  localparam logic [PW-1:0] PIPE_PKT  = {2'b01, 80'h1111_2222_3333_4444_5555};
  localparam logic [PW-1:0] PTW_PKT   = {2'b10, 80'h9999_8888_7777_6666_5555};
  localparam logic [TW-1:0] PIPE_PTAG = 28'h0000123;
  localparam logic [TW-1:0] PTW_PTAG  = 28'h0ABCDEF;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic flush_i = 1'b0;
  logic pipe_v_i = 1'b0;
  logic [PW-1:0] pipe_pkt_i;
  logic pipe_ready_o;
  logic [TW-1:0] pipe_ptag_i;
  logic pipe_ptag_v_i = 1'b0;
  logic pipe_early_v_o, pipe_miss_o;
  logic ptw_req_i = 1'b0;
  logic ptw_grant_o;
  logic ptw_v_i = 1'b0;
  logic [PW-1:0] ptw_pkt_i;
  logic ptw_ready_o;
  logic [TW-1:0] ptw_ptag_i;
  logic ptw_ptag_v_i = 1'b0;
  logic ptw_early_v_o;
  logic dcache_v_o;
  logic [PW-1:0] dcache_pkt_o;
  logic dcache_ready_i = 1'b0;
  logic [TW-1:0] dcache_ptag_o;
  logic dcache_ptag_v_o;
  logic dcache_early_v_i = 1'b0;

  always #5 clk = ~clk;

  bp_be_dcache_port_arbiter #(.pkt_width_p(PW), .ptag_width_p(TW)) dut (
    .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i),
    .pipe_v_i(pipe_v_i), .pipe_pkt_i(pipe_pkt_i), .pipe_ready_o(pipe_ready_o),
    .pipe_ptag_i(pipe_ptag_i), .pipe_ptag_v_i(pipe_ptag_v_i),
    .pipe_early_v_o(pipe_early_v_o), .pipe_miss_o(pipe_miss_o),
    .ptw_req_i(ptw_req_i), .ptw_grant_o(ptw_grant_o),
    .ptw_v_i(ptw_v_i), .ptw_pkt_i(ptw_pkt_i), .ptw_ready_o(ptw_ready_o),
    .ptw_ptag_i(ptw_ptag_i), .ptw_ptag_v_i(ptw_ptag_v_i), .ptw_early_v_o(ptw_early_v_o),
    .dcache_v_o(dcache_v_o), .dcache_pkt_o(dcache_pkt_o), .dcache_ready_i(dcache_ready_i),
    .dcache_ptag_o(dcache_ptag_o), .dcache_ptag_v_o(dcache_ptag_v_o),
    .dcache_early_v_i(dcache_early_v_i)
  );

  // stim: {reset, flush, pipe_v, ptw_req, ptw_v, dcache_ready, pipe_ptag_v, ptw_ptag_v, early_v}
  // exp : {pipe_ready, ptw_ready, grant, dcache_v, ptag_v, pipe_early, pipe_miss, ptw_early}
  // tag : 0 no ptag check, 1 expect pipe ptag, 2 expect PTW ptag
  typedef struct {
    logic [8:0] stim;
    logic [7:0] exp;
    logic [1:0] tag;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int fails  = 0;

  logic [7:0] obs;
  assign obs = {pipe_ready_o, ptw_ready_o, ptw_grant_o, dcache_v_o,
                dcache_ptag_v_o, pipe_early_v_o, pipe_miss_o, ptw_early_v_o};

  task automatic add(input logic [8:0] s, input logic [7:0] e, input logic [1:0] t);
    vec_t v;
    v.stim = s; v.exp = e; v.tag = t;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic [8:0] s);
    {reset_i, flush_i, pipe_v_i, ptw_req_i, ptw_v_i, dcache_ready_i,
     pipe_ptag_v_i, ptw_ptag_v_i, dcache_early_v_i} = s;
  endtask

  task automatic check_vec(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: outputs got %b expected %b", name, got, want);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, got, want);
    end
  endtask

  initial begin
    pipe_pkt_i  = PIPE_PKT;
    ptw_pkt_i   = PTW_PKT;
    pipe_ptag_i = PIPE_PTAG;
    ptw_ptag_i  = PTW_PTAG;

    // reset held: nothing offered
    add(9'b1_0_1_0_0_1_0_0_0, 8'b00000000, 0);
    // back-to-back pipe loads, ptag 0x123, early valid
    add(9'b0_0_1_0_0_1_1_0_1, 8'b10010000, 0);
    add(9'b0_0_1_0_0_1_1_0_1, 8'b10011000, 1);
    add(9'b0_0_1_0_0_1_1_0_1, 8'b10011100, 1);
    add(9'b0_0_0_0_0_1_1_0_1, 8'b10001100, 1);
    add(9'b0_0_0_0_0_1_1_0_1, 8'b10000100, 0);
    add(9'b0_0_0_0_0_1_0_0_0, 8'b10000000, 0);
    // pipe miss
    add(9'b0_0_1_0_0_1_0_0_0, 8'b10010000, 0);
    add(9'b0_0_0_0_0_1_1_0_0, 8'b10001000, 1);
    add(9'b0_0_0_0_0_1_0_0_0, 8'b10000010, 0);
    add(9'b0_0_0_0_0_1_0_0_0, 8'b10000000, 0);
    // drain: accept, ptw_req next cycle, grant three cycles later
    add(9'b0_0_1_0_0_1_0_0_0, 8'b10010000, 0);
    add(9'b0_0_0_1_0_1_1_0_0, 8'b00001000, 1);
    add(9'b0_0_0_1_0_1_0_0_1, 8'b00000100, 0);
    add(9'b0_0_0_1_0_1_0_0_0, 8'b00000000, 0);
    add(9'b0_0_0_1_1_1_0_0_0, 8'b01110000, 0);
    add(9'b0_0_0_1_0_1_0_1_0, 8'b01101000, 2);
    add(9'b0_0_0_0_0_1_0_0_1, 8'b01100001, 0);
    add(9'b0_0_0_0_0_1_0_0_0, 8'b10000000, 0);
    // ptw_req and pipe_v rise together on an idle port: PTW wins, 1-cycle grant
    add(9'b0_0_1_1_0_1_0_0_0, 8'b00000000, 0);
    add(9'b0_0_0_1_1_1_0_0_0, 8'b01110000, 0);
    add(9'b0_0_0_1_0_1_0_1_0, 8'b01101000, 2);
    add(9'b0_0_0_1_0_1_0_0_1, 8'b01100001, 0);
    add(9'b0_0_0_0_0_1_0_0_0, 8'b01100000, 0);
    add(9'b0_0_0_0_0_1_0_0_0, 8'b10000000, 0);
    // PTW accept, req drops next cycle, trailing response still routed to PTW
    add(9'b0_0_0_1_0_1_0_0_0, 8'b00000000, 0);
    add(9'b0_0_0_1_1_1_0_0_0, 8'b01110000, 0);
    add(9'b0_0_0_0_0_1_0_1_0, 8'b01101000, 2);
    add(9'b0_0_0_0_0_1_0_0_1, 8'b10000001, 0);
    // flush in TL kills the entry; flush in TV suppresses same-cycle outputs
    add(9'b0_0_1_0_0_1_1_0_0, 8'b10010000, 0);
    add(9'b0_1_0_0_0_1_1_0_0, 8'b10000000, 0);
    add(9'b0_0_0_0_0_1_0_0_1, 8'b10000000, 0);
    add(9'b0_0_1_0_0_1_0_0_0, 8'b10010000, 0);
    add(9'b0_0_0_0_0_1_1_0_0, 8'b10001000, 1);
    add(9'b0_1_0_0_0_1_0_0_1, 8'b10000000, 0);
    add(9'b0_0_0_0_0_1_0_0_1, 8'b10000000, 0);
    // flush during drain shortens the handoff
    add(9'b0_0_1_0_0_1_0_0_0, 8'b10010000, 0);
    add(9'b0_0_0_1_0_1_0_0_0, 8'b00000000, 0);
    add(9'b0_1_0_1_0_1_0_0_0, 8'b00000000, 0);
    add(9'b0_0_0_1_0_1_0_0_0, 8'b01100000, 0);
    add(9'b0_0_0_0_0_1_0_0_0, 8'b01100000, 0);
    add(9'b0_0_0_0_0_1_0_0_0, 8'b10000000, 0);
    // dcache_ready low stalls acceptance only; ptw_v outside PTW ignored
    add(9'b0_0_1_0_1_0_0_0_0, 8'b00000000, 0);
    add(9'b0_0_1_0_0_1_0_0_0, 8'b10010000, 0);
    add(9'b0_0_1_0_0_0_1_0_0, 8'b00001000, 1);
    add(9'b0_0_0_0_0_1_0_0_1, 8'b10000100, 0);
    add(9'b0_0_0_0_0_1_0_0_0, 8'b10000000, 0);

    drive(9'b1_0_0_0_0_0_0_0_0);
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      drive(tbl[i].stim);
      #3;
      check_vec($sformatf("row%0d", i), obs, tbl[i].exp);
      if (tbl[i].exp[4]) begin
        checks++;
        if (dcache_pkt_o !== (tbl[i].exp[5] ? PTW_PKT : PIPE_PKT)) begin
          fails++;
          $display("FAIL row%0d_pkt: got %h expected %h", i, dcache_pkt_o,
                   tbl[i].exp[5] ? PTW_PKT : PIPE_PKT);
        end
      end
      if (tbl[i].tag != 2'd0) begin
        checks++;
        if (dcache_ptag_o !== ((tbl[i].tag == 2'd2) ? PTW_PTAG : PIPE_PTAG)) begin
          fails++;
          $display("FAIL row%0d_ptag: got %h expected %h", i, dcache_ptag_o,
                   (tbl[i].tag == 2'd2) ? PTW_PTAG : PIPE_PTAG);
        end
      end
    end

    // asynchronous reset mid-walk with a live PTW entry in TL
    @(posedge clk); #1;
    drive(9'b0_0_0_1_0_1_0_0_0);
    #3 check_bit("walk_pre_grant", ptw_grant_o, 1'b0);
    @(posedge clk); #1;
    drive(9'b0_0_0_1_1_1_0_0_0);
    #3 check_vec("walk_accept", obs, 8'b01110000);
    @(posedge clk); #1;
    drive(9'b0_0_0_1_0_1_0_1_0);
    #1 check_bit("walk_tl_ptag_v", dcache_ptag_v_o, 1'b1);
    #1 reset_i = 1'b1;
    #1 check_vec("async_reset_outputs", obs, 8'b00000000);
    @(posedge clk); #1;
    drive(9'b0_0_0_0_0_1_0_0_1);
    #3 check_vec("post_reset_pipe", obs, 8'b10000000);
    @(posedge clk); #1;
    check_bit("post_reset_no_early", ptw_early_v_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
